parking_sensor_frontend: RTL



---
 rtl/parking_sensor_frontend.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/parking_sensor_frontend.sv
// parking_sensor_frontend
//   Conditions the raw entrance/exit loop detectors for the parking gate
//   controller. Both inputs are synchronised through two flops and then
//   debounced. The block tracks occupancy against CAPACITY and refuses
//   arrivals while the lot is full.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   raw_entrance     asynchronous, bouncy entrance loop detector
//   raw_exit         asynchronous, bouncy exit loop detector
//   sensor_entrance  admitted vehicle present at the entrance
//   sensor_exit      debounced exit presence
//   car_count        current occupancy, 0..CAPACITY
//   lot_full         car_count == CAPACITY
//   lot_empty        car_count == 0
//   entry_pulse      1-cycle pulse, vehicle admitted
//   exit_pulse       1-cycle pulse, vehicle departed
//   reject_pulse     1-cycle pulse, arrival refused (lot full)
//   underflow_err    sticky: exit seen while the lot was empty
module parking_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic [CNT_W-1:0] car_count,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             reject_pulse,
  output logic             underflow_err
);

  // Debounce counter only has to hold 0..DEBOUNCE_CYCLES-1.
  localparam int               DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CAP) ? CAP : v + ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  logic            entr_sync_p0, entr_sync_p1;
  logic            exit_sync_p0, exit_sync_p1;
  logic            stable_entr_p2, stable_exit_p2;
  logic [DB_W-1:0] entr_cnt_p2, exit_cnt_p2;

  logic            entr_diff, entr_fire, entr_rise, entr_fall;
  logic            exit_diff, exit_fire, exit_rise;
  logic [DB_W-1:0] entr_cnt_nxt, exit_cnt_nxt;

  logic [CNT_W-1:0] count_nxt;
  logic             admit_nxt, entry_nxt, exitp_nxt, reject_nxt, uflow_nxt;
  logic             full_now, empty_now;

  // Debounce decision: the stable level flips on the DEBOUNCE_CYCLES-th
  // consecutive mismatching sample; any agreeing sample restarts the count.
  always_comb begin
    entr_diff    = entr_sync_p1 ^ stable_entr_p2;
    entr_fire    = entr_diff && (entr_cnt_p2 == DB_LAST);
    entr_rise    = entr_fire && !stable_entr_p2;
    entr_fall    = entr_fire && stable_entr_p2;
    entr_cnt_nxt = (entr_diff && !entr_fire) ? entr_cnt_p2 + DB_ONE : '0;

    exit_diff    = exit_sync_p1 ^ stable_exit_p2;
    exit_fire    = exit_diff && (exit_cnt_p2 == DB_LAST);
    exit_rise    = exit_fire && !stable_exit_p2;
    exit_cnt_nxt = (exit_diff && !exit_fire) ? exit_cnt_p2 + DB_ONE : '0;
  end

  // Occupancy bookkeeping. A simultaneous entry and exit always nets to
  // zero: when full the exit frees the space first, when empty the entry
  // supplies the car the exit removes, so neither refusal nor underflow.
  always_comb begin
    full_now   = (car_count == CAP);
    empty_now  = (car_count == '0);
    count_nxt  = car_count;
    admit_nxt  = sensor_entrance;
    entry_nxt  = 1'b0;
    exitp_nxt  = 1'b0;
    reject_nxt = 1'b0;
    uflow_nxt  = underflow_err;

    if (entr_rise && exit_rise) begin
      entry_nxt = 1'b1;
      exitp_nxt = 1'b1;
      admit_nxt = 1'b1;
    end else if (entr_rise) begin
      if (!full_now) begin
        count_nxt = sat_inc(car_count);
        entry_nxt = 1'b1;
        admit_nxt = 1'b1;
      end else begin
        reject_nxt = 1'b1;
      end
    end else if (exit_rise) begin
      if (!empty_now) begin
        count_nxt = sat_dec(car_count);
        exitp_nxt = 1'b1;
      end else begin
        uflow_nxt = 1'b1;
      end
    end

    if (entr_fall) begin
      admit_nxt = 1'b0;
    end
  end

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge clk) begin
    if (reset) begin
      entr_sync_p0 <= 1'b0;
      entr_sync_p1 <= 1'b0;
      exit_sync_p0 <= 1'b0;
      exit_sync_p1 <= 1'b0;
    end else begin
      entr_sync_p0 <= raw_entrance;
      entr_sync_p1 <= entr_sync_p0;
      exit_sync_p0 <= raw_exit;
      exit_sync_p1 <= exit_sync_p0;
    end
  end

  // Stage p2: debounced levels, counters, occupancy and event outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_entr_p2  <= 1'b0;
      stable_exit_p2  <= 1'b0;
      entr_cnt_p2     <= '0;
      exit_cnt_p2     <= '0;
      sensor_entrance <= 1'b0;
      car_count       <= '0;
      lot_full        <= 1'b0;
      lot_empty       <= 1'b1;
      entry_pulse     <= 1'b0;
      exit_pulse      <= 1'b0;
      reject_pulse    <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      stable_entr_p2  <= stable_entr_p2 ^ entr_fire;
      stable_exit_p2  <= stable_exit_p2 ^ exit_fire;
      entr_cnt_p2     <= entr_cnt_nxt;
      exit_cnt_p2     <= exit_cnt_nxt;
      sensor_entrance <= admit_nxt;
      car_count       <= count_nxt;
      lot_full        <= (count_nxt == CAP);
      lot_empty       <= (count_nxt == '0);
      entry_pulse     <= entry_nxt;
      exit_pulse      <= exitp_nxt;
      reject_pulse    <= reject_nxt;
      underflow_err   <= uflow_nxt;
    end
  end

  assign sensor_exit = stable_exit_p2;

endmodule
